// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution accumulate/requantize datapath.
package conv_pkg;

  localparam int unsigned PROD_W = 21;
  localparam int unsigned OUT_W  = 8;
  localparam int unsigned ACC_W  = 32;

  typedef logic [PROD_W-1:0] prod_t;
  typedef logic [ACC_W-1:0]  acc_t;
  typedef logic [OUT_W-1:0]  pix_t;

  typedef enum logic [0:0] {
    IDLE,
    ACC
  } acc_state_e;

  // Ceiling log2; clog2(0) and clog2(1) both return 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (v > 0 && ((v - 1) >> i) != 0) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_requant_sat.sv
// Combinational round-half-up, right shift and unsigned saturation of an accumulator to a pixel.
module conv_requant_sat #(
  parameter int unsigned ACC_W = conv_pkg::ACC_W,
  parameter int unsigned SHIFT = 4,
  parameter int unsigned OUT_W = conv_pkg::OUT_W
) (
  input  logic [ACC_W-1:0] acc,
  output logic [OUT_W-1:0] pix
);

  localparam logic [ACC_W-1:0] Round  = ACC_W'((64'd1 << SHIFT) >> 1);
  localparam logic [ACC_W-1:0] PixMax = ACC_W'((64'd1 << OUT_W) - 64'd1);

  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] q;

  always_comb begin
    sum = acc + Round;
    q   = sum >> SHIFT;
    pix = (q > PixMax) ? '1 : q[OUT_W-1:0];
  end

endmodule

// File: rtl/conv_acc_requant.sv
// Accumulates TERMS products plus bias per window and emits a requantized pixel on a
// single-entry valid/ready output register.
module conv_acc_requant #(
  parameter int unsigned PROD_W = conv_pkg::PROD_W,
  parameter int unsigned TERMS  = 9,
  parameter int unsigned ACC_W  = conv_pkg::ACC_W,
  parameter int unsigned SHIFT  = 4,
  parameter int unsigned OUT_W  = conv_pkg::OUT_W
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [PROD_W-1:0] prod_tdata,
  input  logic              prod_tvalid,
  input  logic              prod_tlast,
  output logic              prod_tready,
  input  logic [15:0]       cfg_bias,
  output logic [OUT_W-1:0]  pix_tdata,
  output logic              pix_tvalid,
  input  logic              pix_tready,
  output logic              err_last,
  input  logic              err_clr
);

  import conv_pkg::*;

  localparam int unsigned CntW = (clog2(TERMS) > 0) ? clog2(TERMS) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TERMS - 1);

  if (TERMS < 1) begin : g_bad_terms
    $error("conv_acc_requant: TERMS must be >= 1");
  end
  if (ACC_W < PROD_W + clog2(TERMS) + 1) begin : g_bad_acc_w
    $error("conv_acc_requant: ACC_W too narrow for PROD_W and TERMS");
  end
  if (SHIFT > ACC_W - 9) begin : g_bad_shift
    $error("conv_acc_requant: SHIFT out of range");
  end

  acc_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] acc_base, acc_next;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0] pix_q, pix_d, pix_sat;
  logic             pix_valid_q, pix_valid_d;
  logic             err_q, err_d;
  logic             last_term, closing, accept, close, mismatch;

  assign last_term = (cnt_q == CntLast);
  // Depends only on tlast and the counter, never on tvalid, so ready has no loop through valid.
  assign closing   = last_term | prod_tlast;

  assign prod_tready = ap_rst_n & ~(pix_valid_q & ~pix_tready & closing);
  assign accept      = prod_tvalid & prod_tready;
  assign close       = accept & closing;
  assign mismatch    = accept & (prod_tlast ^ last_term);

  // The first term of a window folds the bias in instead of the stale accumulator.
  assign acc_base = (state_q == IDLE) ? ACC_W'(cfg_bias) : acc_q;
  assign acc_next = acc_base + ACC_W'(prod_tdata);

  conv_requant_sat #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W)
  ) u_sat (
    .acc (acc_next),
    .pix (pix_sat)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    pix_d       = pix_q;
    pix_valid_d = pix_valid_q;
    err_d       = err_q;

    if (pix_valid_q && pix_tready) pix_valid_d = 1'b0;

    if (accept) begin
      if (close) begin
        state_d     = IDLE;
        cnt_d       = '0;
        acc_d       = '0;
        pix_d       = pix_sat;
        pix_valid_d = 1'b1;
      end else begin
        state_d = ACC;
        cnt_d   = cnt_q + CntW'(1);
        acc_d   = acc_next;
      end
    end

    if (mismatch) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      pix_q       <= '0;
      pix_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      pix_q       <= pix_d;
      pix_valid_q <= pix_valid_d;
      err_q       <= err_d;
    end
  end

  assign pix_tdata  = pix_q;
  assign pix_tvalid = pix_valid_q;
  assign err_last   = err_q;

endmodule

// File: tb/tb_conv_acc_requant.sv
// Scoreboard bench: dut 0 runs a 3x3 window (TERMS=9, SHIFT=4), dut 1 runs TERMS=1, SHIFT=0.
module tb_conv_acc_requant;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [20:0] p_data [2];
  logic        p_valid [2];
  logic        p_last [2];
  logic        p_ready [2];
  logic [15:0] bias [2];
  logic [7:0]  pix_data [2];
  logic        pix_valid [2];
  logic        pix_ready [2];
  logic        err [2];
  logic        err_clr [2];

  logic        rnd_rdy;
  logic        rnd_bit [2];
  logic        fix_rdy [2];

  int          n_checks = 0;
  int          n_fail = 0;

  int          terms [2] = '{9, 1};
  int          shf [2] = '{4, 0};
  int          cnt [2];
  longint      sum [2];
  bit          err_m [2];
  int          exp0 [$];
  int          exp1 [$];
  bit          hold [2];
  logic [7:0]  hdata [2];

  assign pix_ready[0] = rnd_rdy ? rnd_bit[0] : fix_rdy[0];
  assign pix_ready[1] = rnd_rdy ? rnd_bit[1] : fix_rdy[1];

  conv_acc_requant #(.TERMS(9), .SHIFT(4)) dut_a (
    .ap_clk      (clk),
    .ap_rst_n    (rst_n),
    .prod_tdata  (p_data[0]),
    .prod_tvalid (p_valid[0]),
    .prod_tlast  (p_last[0]),
    .prod_tready (p_ready[0]),
    .cfg_bias    (bias[0]),
    .pix_tdata   (pix_data[0]),
    .pix_tvalid  (pix_valid[0]),
    .pix_tready  (pix_ready[0]),
    .err_last    (err[0]),
    .err_clr     (err_clr[0])
  );

  conv_acc_requant #(.TERMS(1), .SHIFT(0)) dut_b (
    .ap_clk      (clk),
    .ap_rst_n    (rst_n),
    .prod_tdata  (p_data[1]),
    .prod_tvalid (p_valid[1]),
    .prod_tlast  (p_last[1]),
    .prod_tready (p_ready[1]),
    .cfg_bias    (bias[1]),
    .pix_tdata   (pix_data[1]),
    .pix_tvalid  (pix_valid[1]),
    .pix_tready  (pix_ready[1]),
    .err_last    (err[1]),
    .err_clr     (err_clr[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Reference requantization straight from the arithmetic definition.
  function automatic int ref_pix(input int d, input longint s);
    longint r, q;
    r = (shf[d] > 0) ? (longint'(1) << (shf[d] - 1)) : 0;
    q = (s + r) >> shf[d];
    return (q > 255) ? 255 : int'(q);
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? exp0.size() : exp1.size();
  endfunction

  // Window model: returns 1 when this accepted term closes the window.
  function automatic bit model_accept(input int d, input int data, input bit last);
    bit lt;
    if (cnt[d] == 0) sum[d] = longint'(bias[d]);
    sum[d] += longint'(data);
    lt = (cnt[d] == terms[d] - 1);
    if (last != lt) err_m[d] = 1'b1;
    if (last || lt) begin
      if (d == 0) exp0.push_back(ref_pix(d, sum[d]));
      else exp1.push_back(ref_pix(d, sum[d]));
      cnt[d] = 0;
      return 1'b1;
    end
    cnt[d]++;
    return 1'b0;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input int d, input int data, input bit last, input logic [15:0] b,
                      output int waited);
    bit closed;
    waited = 0;
    p_data[d] = 21'(data);
    p_last[d] = last;
    bias[d] = b;
    p_valid[d] = 1'b1;
    #1;
    while (p_ready[d] !== 1'b1 && waited < 300) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (p_ready[d] !== 1'b1) begin
      check("accept_timeout", p_ready[d], 1);
      @(negedge clk);
      p_valid[d] = 1'b0;
      return;
    end
    @(posedge clk);
    closed = model_accept(d, data, last);
    @(negedge clk);
    p_valid[d] = 1'b0;
    p_last[d] = 1'b0;
    check("err_last", err[d], err_m[d]);
    if (closed) check("latency_valid", pix_valid[d], 1);
  endtask

  task automatic pulse_clr(input int d);
    err_clr[d] = 1'b1;
    @(posedge clk);
    err_m[d] = 1'b0;
    @(negedge clk);
    err_clr[d] = 1'b0;
    check("err_clr", err[d], err_m[d]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", p_ready[d], 0);
      check("rst_valid", pix_valid[d], 0);
      check("rst_data", pix_data[d], 0);
      check("rst_err", err[d], 0);
      cnt[d] = 0;
      err_m[d] = 1'b0;
    end
    exp0.delete();
    exp1.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) check("release_ready", p_ready[d], 1);
    @(negedge clk);
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while (qsize(d) != 0 && n < 300) begin
      @(negedge clk);
      #3;
      n++;
    end
    check("drain_empty", qsize(d), 0);
    @(negedge clk);
  endtask

  function automatic int rnd_prod();
    return int'($urandom_range(0, 32'h1FFFFF) >> $urandom_range(0, 20));
  endfunction

  always @(negedge clk) begin
    rnd_bit[0] <= 1'($urandom_range(0, 1));
    rnd_bit[1] <= 1'($urandom_range(0, 1));
  end

  // Monitor: acts only when the DUT presents a pixel; checks stall stability and pops on transfer.
  always @(negedge clk) begin
    #2;
    for (int d = 0; d < 2; d++) begin
      if (rst_n !== 1'b1) begin
        hold[d] = 1'b0;
      end else begin
        if (hold[d]) begin
          check("hold_valid", pix_valid[d], 1);
          check("hold_data", pix_data[d], hdata[d]);
        end
        if (pix_valid[d] === 1'b1 && pix_ready[d] === 1'b1) begin
          if (qsize(d) == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pixel: dut %0d actual %0d required none", d, pix_data[d]);
          end else if (d == 0) begin
            check("pix_data_a", pix_data[d], exp0.pop_front());
          end else begin
            check("pix_data_b", pix_data[d], exp1.pop_front());
          end
        end
        hold[d] = (pix_valid[d] === 1'b1) && (pix_ready[d] !== 1'b1);
        hdata[d] = pix_data[d];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, len;
    bit lst;
    rnd_rdy = 1'b0;
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      p_data[d] = '0;
      p_valid[d] = 1'b0;
      p_last[d] = 1'b0;
      bias[d] = '0;
      err_clr[d] = 1'b0;
      fix_rdy[d] = 1'b1;
      hold[d] = 1'b0;
    end
    @(negedge clk);
    do_reset();

    // Nine 16s, bias 0 -> (144+8)>>4 = 9
    for (int i = 0; i < 9; i++) send(0, 16, i == 8, 16'd0, w);
    drain(0);

    // Nine 2^20 with bias 0xFFFF saturates
    for (int i = 0; i < 9; i++) send(0, 1 << 20, i == 8, 16'hFFFF, w);
    drain(0);

    // Output stall: window 2 terms 1-8 flow, term 9 waits for the held pixel to drain
    fix_rdy[0] = 1'b0;
    for (int i = 0; i < 9; i++) send(0, rnd_prod(), i == 8, 16'($urandom_range(0, 255)), w);
    for (int i = 0; i < 8; i++) begin
      send(0, rnd_prod(), 1'b0, 16'($urandom_range(0, 255)), w);
      check("nonclose_wait", w, 0);
    end
    fork
      send(0, rnd_prod(), 1'b1, 16'd0, w);
      begin
        repeat (5) begin
          @(negedge clk);
          #1;
          check("stall_ready", p_ready[0], 0);
        end
        @(negedge clk);
        fix_rdy[0] = 1'b1;
      end
    join
    check("stall_wait", w, 6);
    drain(0);

    // Early tlast on 5th term: (160+8)>>4 = 10 and sticky error
    for (int i = 0; i < 5; i++) send(0, 32, i == 4, 16'd0, w);
    drain(0);
    for (int i = 0; i < 9; i++) send(0, 16, i == 8, 16'd0, w);
    drain(0);
    pulse_clr(0);

    // Reset mid-window discards the partial sum
    for (int i = 0; i < 4; i++) send(0, 16, 1'b0, 16'd0, w);
    do_reset();
    for (int i = 0; i < 9; i++) send(0, 16, i == 8, 16'd0, w);
    drain(0);

    // Single-term windows
    send(1, 3, 1'b1, 16'd0, w);
    send(1, 300, 1'b1, 16'd0, w);
    send(1, 7, 1'b1, 16'd0, w);
    drain(1);

    // Random windows under random backpressure
    rnd_rdy = 1'b1;
    for (int win = 0; win < 40; win++) begin
      len = $urandom_range(1, 9);
      for (int k = 0; k < len; k++) begin
        lst = (k == len - 1) && (len < 9 || $urandom_range(0, 3) != 0);
        send(0, rnd_prod(), lst,
             ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255)), w);
      end
      if ($urandom_range(0, 4) == 0) pulse_clr(0);
    end
    for (int i = 0; i < 30; i++) begin
      send(1, int'($urandom_range(0, 600)), 1'b1, 16'($urandom_range(0, 3)), w);
    end
    rnd_rdy = 1'b0;
    drain(0);
    drain(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
